// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared types and constants for the up/down modulo counter family
//             (direction encoding and end-of-range mode selectors).
//  Revision : 1.0  initial release
// ============================================================================
package counter_pkg;

  // Count direction as seen on the 'up' input
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // End-of-range behaviour selectors for the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_next.sv
`default_nettype none
// ============================================================================
//  Module   : counter_next
//  Purpose  : Combinational next-count generator for a modulo up/down counter.
//             Given the present count, the direction and the terminal-count
//             flag, it produces the following count under the MODULO and
//             SATURATE rules. Shared with the timer blocks.
//  Revision : 1.0  initial release
// ============================================================================
module counter_next
  import counter_pkg::*;
#(
  parameter int N        = 3,
  parameter int MODULO   = 2**N,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [N-1:0] counter,
  input  logic         up,
  input  logic         tc,
  output logic [N-1:0] next_cnt
);

  // Range limits; the modulus itself needs N+1 bits when MODULO == 2**N
  localparam logic [N:0]   c_mod_w = (N+1)'(MODULO);
  localparam logic [N-1:0] c_max   = N'(MODULO - 1);

  dir_t       w_dir;
  logic [N:0] w_inc;
  logic [N:0] w_dec;

  assign w_dir = dir_t'(up);

  // One extra bit keeps the carry/borrow visible so the range check never
  // depends on the natural 2**N rollover of an N-bit register.
  assign w_inc = {1'b0, counter} + (N+1)'(1);
  assign w_dec = {1'b0, counter} - (N+1)'(1);

  // Select the next count: step normally inside the range, wrap or hold at the ends
  always_comb begin
    next_cnt = counter;
    if (w_dir == DIR_UP) begin
      if (tc || (w_inc >= c_mod_w)) begin
        next_cnt = (SATURATE == MODE_SAT) ? c_max : '0;
      end else begin
        next_cnt = w_inc[N-1:0];
      end
    end else begin
      if (tc || w_dec[N]) begin
        next_cnt = (SATURATE == MODE_SAT) ? '0 : c_max;
      end else begin
        next_cnt = w_dec[N-1:0];
      end
    end
  end

endmodule : counter_next
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
//  Module   : counter_updown_mod
//  Purpose  : Parametrised up/down modulo counter with count enable, direction
//             select, clamped parallel load, wrap or saturate mode, a
//             combinational terminal-count flag, a one-cycle wrap pulse and a
//             sticky overflow flag.
//  Revision : 1.0  initial release
// ============================================================================
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int N        = 3,
  parameter int MODULO   = 2**N,
  parameter int SATURATE = MODE_WRAP,
  parameter int RST_VAL  = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         ovf_clr,
  output logic [N-1:0] counter,
  output logic         tc,
  output logic         wrap,
  output logic         ovf
);

  localparam logic [N:0]   c_mod_w = (N+1)'(MODULO);
  localparam logic [N-1:0] c_max   = N'(MODULO - 1);
  localparam logic [N-1:0] c_rst   = N'(RST_VAL);

  logic [N-1:0] r_counter;
  logic         r_wrap;
  logic         r_ovf;

  dir_t         w_dir;
  logic         w_tc;
  logic         w_event;
  logic [N-1:0] w_next;
  logic [N-1:0] w_load_clamped;

  assign w_dir = dir_t'(up);

  // Terminal count looks only at en, up and the present count, so there is
  // no combinational path from load or load_val to this output.
  assign w_tc = en & ((w_dir == DIR_UP) ? (r_counter == c_max)
                                        : (r_counter == '0));

  // A range-end event is an enabled step at the end of the range; a load
  // in the same cycle pre-empts the step and therefore the event.
  assign w_event = w_tc & ~load;

  // Out-of-range load values are clamped to the top of the range
  assign w_load_clamped = ({1'b0, load_val} >= c_mod_w) ? c_max : load_val;

  counter_next #(
    .N        (N),
    .MODULO   (MODULO),
    .SATURATE (SATURATE)
  ) u_counter_next (
    .counter  (r_counter),
    .up       (up),
    .tc       (w_tc),
    .next_cnt (w_next)
  );

  // Counter, wrap pulse and sticky overflow; priority reset > load > enable > hold
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_counter <= c_rst;
      r_wrap    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (load) begin
        r_counter <= w_load_clamped;
      end else if (en) begin
        r_counter <= w_next;
      end
      r_wrap <= w_event;
      // Setting wins over a simultaneous clear request
      r_ovf  <= w_event | (r_ovf & ~ovf_clr);
    end
  end

  assign counter = r_counter;
  assign tc      = w_tc;
  assign wrap    = r_wrap;
  assign ovf     = r_ovf;

endmodule : counter_updown_mod
`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_updown_mod
//  Purpose  : Self-checking bench for counter_updown_mod. Three instances
//             (MODULO 6 wrap, MODULO 6 saturate, MODULO 8 wrap) share one
//             stimulus stream and are compared with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] dut_cnt  [3];
  logic       dut_tc   [3];
  logic       dut_wrap [3];
  logic       dut_ovf  [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state per instance
  int m_mod  [3] = '{6, 6, 8};
  int m_sat  [3] = '{0, 1, 0};
  int m_cnt  [3] = '{0, 0, 0};
  int m_wrap [3] = '{0, 0, 0};
  int m_ovf  [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  counter_updown_mod #(.N(3), .MODULO(6), .SATURATE(0), .RST_VAL(0)) u_wrap6 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .counter(dut_cnt[0]), .tc(dut_tc[0]),
    .wrap(dut_wrap[0]), .ovf(dut_ovf[0])
  );

  counter_updown_mod #(.N(3), .MODULO(6), .SATURATE(1), .RST_VAL(0)) u_sat6 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .counter(dut_cnt[1]), .tc(dut_tc[1]),
    .wrap(dut_wrap[1]), .ovf(dut_ovf[1])
  );

  counter_updown_mod #(.N(3), .MODULO(8), .SATURATE(0), .RST_VAL(0)) u_wrap8 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .counter(dut_cnt[2]), .tc(dut_tc[2]),
    .wrap(dut_wrap[2]), .ovf(dut_ovf[2])
  );

  // Single comparison point
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected terminal count from the model's present count and current inputs
  function automatic int exp_tc(input int k);
    if (!en) return 0;
    if (up) return (m_cnt[k] == m_mod[k] - 1) ? 1 : 0;
    return (m_cnt[k] == 0) ? 1 : 0;
  endfunction

  // Advance the model by one rising edge using the rules of the counter
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int ev;
      ev = (clr && !load && exp_tc(k) == 1) ? 1 : 0;
      if (!clr) begin
        m_cnt[k]  = 0;
        m_wrap[k] = 0;
        m_ovf[k]  = 0;
      end else begin
        if (load) begin
          m_cnt[k] = (int'(load_val) >= m_mod[k]) ? m_mod[k] - 1 : int'(load_val);
        end else if (en) begin
          if (up) begin
            if (m_sat[k] != 0) m_cnt[k] = (m_cnt[k] + 1 > m_mod[k] - 1) ? m_mod[k] - 1 : m_cnt[k] + 1;
            else               m_cnt[k] = (m_cnt[k] + 1) % m_mod[k];
          end else begin
            if (m_sat[k] != 0) m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
            else               m_cnt[k] = (m_cnt[k] + m_mod[k] - 1) % m_mod[k];
          end
        end
        m_wrap[k] = ev;
        if (ev != 0)     m_ovf[k] = 1;
        else if (ovf_clr) m_ovf[k] = 0;
      end
    end
  endtask

  // One clock cycle: drive on the falling edge, check tc before the rising
  // edge, then check registered outputs just after it.
  task automatic cycle(input logic c, input logic e, input logic u,
                       input logic l, input int lv, input logic oc);
    @(negedge clk);
    clr      = c;
    en       = e;
    up       = u;
    load     = l;
    load_val = 3'(lv);
    ovf_clr  = oc;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("tc[%0d]", k), int'(dut_tc[k]), exp_tc(k));
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("counter[%0d]", k), int'(dut_cnt[k]), m_cnt[k]);
      check($sformatf("wrap[%0d]", k),    int'(dut_wrap[k]), m_wrap[k]);
      check($sformatf("ovf[%0d]", k),     int'(dut_ovf[k]), m_ovf[k]);
    end
  endtask

  initial begin
    // Reset for two cycles
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("reset_cnt6", int'(dut_cnt[0]), 0);
    check("reset_ovf6", int'(dut_ovf[0]), 0);

    // Count up through the range end
    for (int i = 0; i < 7; i++) cycle(1, 1, 1, 0, 0, 0);
    check("up_wrap6_cnt", int'(dut_cnt[0]), 1);
    check("up_ovf6", int'(dut_ovf[0]), 1);

    // Count down with a frozen stretch in the middle
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 0);

    // Load 4 then count up into the top: saturating instance holds at 5
    cycle(1, 0, 0, 1, 4, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0, 0);
    check("sat_hold_cnt", int'(dut_cnt[1]), 5);
    check("sat_hold_wrap", int'(dut_wrap[1]), 1);

    // Clamped load, then load overriding enable
    cycle(1, 0, 0, 1, 7, 0);
    check("clamp6", int'(dut_cnt[0]), 5);
    check("noclamp8", int'(dut_cnt[2]), 7);
    cycle(1, 1, 1, 1, 2, 0);
    check("load_over_en", int'(dut_cnt[0]), 2);
    check("load_no_wrap", int'(dut_wrap[0]), 0);

    // ovf set and ovf_clr together: set wins; then clear alone
    cycle(1, 0, 0, 1, 5, 0);
    cycle(1, 1, 1, 0, 0, 1);
    check("ovf_set_wins", int'(dut_ovf[0]), 1);
    cycle(1, 0, 1, 0, 0, 1);
    check("ovf_cleared", int'(dut_ovf[0]), 0);

    // Reset mid-count together with a load
    cycle(1, 0, 0, 1, 3, 0);
    cycle(0, 1, 1, 1, 6, 1);
    check("rst_over_load", int'(dut_cnt[0]), 0);

    // Natural 7 -> 0 wrap on the MODULO 8 instance
    cycle(1, 0, 0, 1, 7, 0);
    cycle(1, 1, 1, 0, 0, 0);
    check("wrap8_cnt", int'(dut_cnt[2]), 0);
    check("wrap8_pulse", int'(dut_wrap[2]), 1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 19) != 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 7)),
            $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_counter_updown_mod
`default_nettype wire
